pause_dim_ctrl: RTL and testbench
=================================

// Module: pause_dim_ctrl
// PURPOSE
//  Parametrised pause and screen-dim controller for arcade cores; sits between the game core's
//  RGB/sync outputs and arcade_video. It merges user-toggle, OSD and N external pause requests
//  into one core pause. After a programmable idle time under user pause it fades the picture in
//  discrete brightness steps. On unpause it restores full brightness at once.
// PARAMETERS
//  NUM_EXT       1          number of external pause requesters (hiscore, loaders, ...)
//  R_W/G_W/B_W   3/3/2      colour channel widths
//  DIM_TIMEOUT   180000000  clk_sys cycles of user pause before dimming starts (>=1)
//  MAX_SHIFT     2          deepest dim level; channel right-shift amount (>=1)
//  FADE_INTERVAL 4800000    clk_sys cycles between successive dim steps (>=1)
// PORTS
//  clk_sys      in   1          system clock; all logic on rising edge
//  reset        in   1          synchronous, active-high
//  pause_btn    in   1          user pause button, level, already synchronous to clk_sys
//  ext_pause    in   NUM_EXT    external pause requests, level
//  osd_open     in   1          OSD visible
//  osd_pause_en in   1          1 = pause while OSD is open
//  pause        out  1          combined pause to core
//  user_paused  out  1          user toggle state
//  dim_level    out  clog2(MAX_SHIFT+1)  current shift, 0 = full brightness
//  r_in,g_in,b_in       in   R_W,G_W,B_W  core pixel
//  hs_in,vs_in,hbl_in,vbl_in in 1       core sync/blank
//  r_out,g_out,b_out    out  R_W,G_W,B_W  dimmed pixel
//  hs_out,vs_out,hbl_out,vbl_out out 1  delayed sync/blank
// BEHAVIOUR
//  - Reset: user_paused=0, dim_level=0, timer=0, fade counter=0, all video outputs 0.
//  - Reset: btn_prev=1, so a button held through reset does not toggle.
//  - Edge detect: rising pause_btn (btn_prev=0, pause_btn=1) toggles user_paused next cycle.
//    Toggling is independent of ext/OSD pause.
//  - pause = user_paused | (|ext_pause) | (osd_open & osd_pause_en).
//    Combinational from registered user_paused; 0 latency from ext/osd inputs.
//  - Idle timer, width clog2(DIM_TIMEOUT+1):
//    - counts +1 per cycle while user_paused=1; saturates at DIM_TIMEOUT;
//    - cleared to 0 the cycle after user_paused=0;
//    - ext/OSD pause alone never advance it.
//  - Dim FSM states: BRIGHT -> WAIT -> FADE -> HELD.
//    - BRIGHT: user_paused=0, dim_level=0.
//    - WAIT: user_paused=1, timer<DIM_TIMEOUT.
//    - FADE: entered when timer reaches DIM_TIMEOUT; dim_level=1 that cycle. Then +1 every
//      FADE_INTERVAL cycles until MAX_SHIFT.
//    - HELD: dim_level=MAX_SHIFT, hold.
//    - Any state with user_paused=0 -> BRIGHT; dim_level=0 and counters cleared the next cycle.
//  - Re-pause after unpause restarts the timer from 0; there is no residual fade.
//  - Video path: one registered stage, latency 1 clk_sys. Per channel x_out <= x_in >> dim_level
//    (logical shift, result 0 if shift >= width). Sync/blank get an identical 1-cycle delay.
//    No ce gating; registers update every cycle.
//  - dim_level changes take effect on pixels registered the following cycle (no mid-pixel
//    glitch requirement).
// CONFIGURATION
//  PAUSE_DIM_FADE_EN defined:
//    - stepped fade as above.
//  PAUSE_DIM_FADE_EN undefined:
//    - FADE_INTERVAL unused, no fade counter;
//    - at timeout dim_level jumps 0 -> MAX_SHIFT in one cycle (WAIT -> HELD directly);
//    - everything else identical.
// TESTING (DIM_TIMEOUT=100, MAX_SHIFT=2, FADE_INTERVAL=10, NUM_EXT=2, 3/3/2 RGB)
//  1. Reset with pause_btn=1, release reset, hold 5 cycles -> user_paused stays 0.
//     Then 0->1 edge -> user_paused=1 one cycle later, pause=1.
//  2. ext_pause=2'b10 only, 500 cycles -> pause=1, user_paused=0, dim_level=0.
//     Drop ext -> pause=0 same cycle.
//  3. User pause, r_in=3'b111,b_in=2'b11 ->
//     - cycle 100 after pause: dim_level=1, r_out=3'b011;
//     - 10 cycles later: dim_level=2, r_out=3'b001, b_out=0;
//     - thereafter stays 2.
//  4. In HELD press button again -> next cycle dim_level=0; following cycle r_out=3'b111.
//     Re-pause -> dim starts 100 cycles later.
//  5. osd_open=1: osd_pause_en=0 -> pause=0; osd_pause_en=1 -> pause=1.
//     Button edge during OSD pause still toggles user_paused.
//  6. Undefine PAUSE_DIM_FADE_EN -> dim_level 0->2 at cycle 100.
//     Also check hs/vs/hbl/vbl delayed exactly 1 cycle.

Source files
------------

// File: rtl/pause_dim_ctrl.sv
// Merges user/OSD/external pause requests and dims the picture after a long user pause.
// Latency: pause is combinational, video and sync are delayed by exactly one clk_sys.
// Backpressure: none; every register updates each cycle. PAUSE_DIM_FADE_EN selects stepped fade.
module pause_dim_ctrl #(
    parameter int NUM_EXT       = 1,
    parameter int R_W           = 3,
    parameter int G_W           = 3,
    parameter int B_W           = 2,
    parameter int DIM_TIMEOUT   = 180000000,
    parameter int MAX_SHIFT     = 2,
    parameter int FADE_INTERVAL = 4800000
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             pause_btn,
    input  logic [NUM_EXT-1:0]               ext_pause,
    input  logic                             osd_open,
    input  logic                             osd_pause_en,
    output logic                             pause,
    output logic                             user_paused,
    output logic [$clog2(MAX_SHIFT+1)-1:0]   dim_level,
    input  logic [R_W-1:0]                   r_in,
    input  logic [G_W-1:0]                   g_in,
    input  logic [B_W-1:0]                   b_in,
    input  logic                             hs_in,
    input  logic                             vs_in,
    input  logic                             hbl_in,
    input  logic                             vbl_in,
    output logic [R_W-1:0]                   r_out,
    output logic [G_W-1:0]                   g_out,
    output logic [B_W-1:0]                   b_out,
    output logic                             hs_out,
    output logic                             vs_out,
    output logic                             hbl_out,
    output logic                             vbl_out
);
    localparam int TW = $clog2(DIM_TIMEOUT + 1);
    localparam int DW = $clog2(MAX_SHIFT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(DIM_TIMEOUT);
    localparam logic [DW-1:0] MAX_V     = DW'(MAX_SHIFT);

    if (DIM_TIMEOUT < 1 || MAX_SHIFT < 1 || FADE_INTERVAL < 1) begin : g_param_check
        $error("pause_dim_ctrl: DIM_TIMEOUT, MAX_SHIFT and FADE_INTERVAL must be >= 1");
    end

    typedef enum logic [1:0] {S_BRIGHT, S_WAIT, S_FADE, S_HELD} state_t;

    state_t          state, state_nxt;
    logic            btn_prev;
    logic [TW-1:0]   timer, timer_nxt;
    logic [DW-1:0]   dim_nxt;

`ifdef PAUSE_DIM_FADE_EN
    localparam int FW = (FADE_INTERVAL > 1) ? $clog2(FADE_INTERVAL) : 1;
    localparam logic [FW-1:0] FADE_LAST = FW'(FADE_INTERVAL - 1);
    logic [FW-1:0]   fade_cnt, fade_nxt;
`endif

    assign pause = user_paused | (|ext_pause) | (osd_open & osd_pause_en);

    always_comb begin
        state_nxt = state;
        dim_nxt   = dim_level;
        timer_nxt = timer;
`ifdef PAUSE_DIM_FADE_EN
        fade_nxt  = fade_cnt;
`endif
        if (!user_paused) begin
            // Unpause restores brightness at once and forgets any partial fade.
            state_nxt = S_BRIGHT;
            dim_nxt   = '0;
            timer_nxt = '0;
`ifdef PAUSE_DIM_FADE_EN
            fade_nxt  = '0;
`endif
        end else begin
            if (timer != TIMEOUT_V) timer_nxt = timer + TW'(1);
            case (state)
                S_BRIGHT, S_WAIT: begin
                    if (timer_nxt == TIMEOUT_V) begin
`ifdef PAUSE_DIM_FADE_EN
                        dim_nxt   = DW'(1);
                        fade_nxt  = '0;
                        state_nxt = (MAX_SHIFT == 1) ? S_HELD : S_FADE;
`else
                        dim_nxt   = MAX_V;
                        state_nxt = S_HELD;
`endif
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
                S_FADE: begin
`ifdef PAUSE_DIM_FADE_EN
                    if (fade_cnt == FADE_LAST) begin
                        fade_nxt = '0;
                        dim_nxt  = dim_level + DW'(1);
                        if (dim_nxt == MAX_V) state_nxt = S_HELD;
                    end else begin
                        fade_nxt = fade_cnt + FW'(1);
                    end
`else
                    dim_nxt   = MAX_V;
                    state_nxt = S_HELD;
`endif
                end
                S_HELD: state_nxt = S_HELD;
                default: state_nxt = S_BRIGHT;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_BRIGHT;
            btn_prev    <= 1'b1;
            user_paused <= 1'b0;
            timer       <= '0;
            dim_level   <= '0;
`ifdef PAUSE_DIM_FADE_EN
            fade_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            btn_prev    <= pause_btn;
            user_paused <= user_paused ^ (pause_btn & ~btn_prev);
            timer       <= timer_nxt;
            dim_level   <= dim_nxt;
`ifdef PAUSE_DIM_FADE_EN
            fade_cnt    <= fade_nxt;
`endif
        end
    end

    // Pixel stage uses the registered level, so a level change lands on the next pixel.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out   <= '0;
            g_out   <= '0;
            b_out   <= '0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            hbl_out <= 1'b0;
            vbl_out <= 1'b0;
        end else begin
            r_out   <= r_in >> dim_level;
            g_out   <= g_in >> dim_level;
            b_out   <= b_in >> dim_level;
            hs_out  <= hs_in;
            vs_out  <= vs_in;
            hbl_out <= hbl_in;
            vbl_out <= vbl_in;
        end
    end
endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Scoreboard bench for pause_dim_ctrl; expected values come from a run-length model of user pause.
module tb_pause_dim_ctrl;
    localparam int T  = 100;
    localparam int MS = 2;
    localparam int FI = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       pause_btn = 1'b1;
    logic [1:0] ext_pause = '0;
    logic       osd_open = 1'b0, osd_pause_en = 1'b0;
    logic       pause, user_paused;
    logic [1:0] dim_level;
    logic [2:0] r_in = '0, g_in = '0, r_out, g_out;
    logic [1:0] b_in = '0, b_out;
    logic       hs_in = 1'b0, vs_in = 1'b0, hbl_in = 1'b0, vbl_in = 1'b0;
    logic       hs_out, vs_out, hbl_out, vbl_out;

    pause_dim_ctrl #(
        .NUM_EXT(2), .R_W(3), .G_W(3), .B_W(2),
        .DIM_TIMEOUT(T), .MAX_SHIFT(MS), .FADE_INTERVAL(FI)
    ) dut (
        .clk_sys(clk), .reset(reset), .pause_btn(pause_btn), .ext_pause(ext_pause),
        .osd_open(osd_open), .osd_pause_en(osd_pause_en), .pause(pause),
        .user_paused(user_paused), .dim_level(dim_level),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .hbl_in(hbl_in), .vbl_in(vbl_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out), .hbl_out(hbl_out), .vbl_out(vbl_out)
    );

    typedef struct packed {
        logic       pause;
        logic       up;
        logic [1:0] dim;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic [3:0] sync;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state for the current cycle: user toggle, button history, length of the
    // unbroken user-pause run before this cycle, and the registered video outputs.
    logic       m_up, m_bprev;
    int         m_run;
    logic [2:0] m_r, m_g;
    logic [1:0] m_b;
    logic [3:0] m_sync;
    logic       fix_vid = 1'b0;

    function automatic int dim_of(input int run);
        if (run < T) return 0;
`ifdef PAUSE_DIM_FADE_EN
        return (1 + (run - T) / FI > MS) ? MS : 1 + (run - T) / FI;
`else
        return MS;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic btn, input logic [1:0] ext, input logic oo, input logic oe);
        exp_t e;
        int   d;
        pause_btn = btn; ext_pause = ext; osd_open = oo; osd_pause_en = oe;
        if (fix_vid) begin
            r_in = 3'b111; g_in = 3'($urandom); b_in = 2'b11;
        end else begin
            {r_in, g_in, b_in} = 8'($urandom);
        end
        {hs_in, vs_in, hbl_in, vbl_in} = 4'($urandom);
        d = dim_of(m_run);
        e.pause = m_up | (|ext) | (oo & oe);
        e.up    = m_up;
        e.dim   = 2'(d);
        e.r     = m_r;
        e.g     = m_g;
        e.b     = m_b;
        e.sync  = m_sync;
        q.push_back(e);
        m_r    = r_in >> d;
        m_g    = g_in >> d;
        m_b    = b_in >> d;
        m_sync = {hs_in, vs_in, hbl_in, vbl_in};
        m_run  = m_up ? m_run + 1 : 0;
        m_up   = m_up ^ (btn & ~m_bprev);
        m_bprev = btn;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pause", pause, e.pause);
            chk("user_paused", user_paused, e.up);
            chk("dim_level", dim_level, e.dim);
            chk("r_out", r_out, e.r);
            chk("g_out", g_out, e.g);
            chk("b_out", b_out, e.b);
            chk("sync_out", {hs_out, vs_out, hbl_out, vbl_out}, e.sync);
        end
    end

    initial begin
        logic btn;
        reset = 1'b1;
        pause_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_up = 1'b0; m_bprev = 1'b1; m_run = 0;
        m_r = '0; m_g = '0; m_b = '0; m_sync = '0;

        // Button held through reset must not toggle; then a clean press pauses.
        repeat (5) step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0);

        // External pause alone never dims.
        repeat (500) step(1'b0, 2'b10, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0);

        // Full-white pixel through the timeout and fade, unpause in HELD, re-pause.
        fix_vid = 1'b1;
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (129) step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (5) step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (120) step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0);
        fix_vid = 1'b0;

        // OSD pause gating and button toggling while OSD pauses.
        repeat (5) step(1'b0, 2'b00, 1'b1, 1'b0);
        repeat (5) step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        repeat (5) step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0);

        // Random traffic with slow button activity so long pauses reach HELD.
        btn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 119) == 0) btn = ~btn;
            step(btn,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
